// File: rtl/spi_chip_select_decoder.sv
// Passive SPI mode-0 sniffer. After a start pulse it decodes a pin-index byte
// and a length byte from MOSI/SCLK, then holds scs high for exactly that many
// following bytes. scs is combinational so its edges land in the same clk
// cycle the final SCLK fall of the qualifying byte is seen.
module spi_chip_select_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sin,
  input  logic       sclk,
  output logic       scs,
  output logic [7:0] sindex
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_GET_INDEX = 2'd1,
    S_GET_COUNT = 2'd2,
    S_ACTIVE    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sclk_q;
  logic [2:0]  r_bitcnt;
  logic        r_full;
  logic [7:0]  r_shift;
  logic [7:0]  r_remaining;
  logic [7:0]  r_sindex;
  logic [7:0]  w_remaining_nxt;
  logic        w_sindex_load;
  logic        w_rise;
  logic        w_fall;
  logic        w_byte_done;
  logic        w_scs;

  // SCLK is already synchronous to clk; edges come from a one-cycle delay.
  assign w_rise = ~r_sclk_q & sclk;
  assign w_fall = r_sclk_q & ~sclk;

  // A byte completes on the fall after the 8th rise; start suppresses it.
  assign w_byte_done = w_fall & r_full & ~start;

  // Previous SCLK level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_q <= 1'b0;
    end else begin
      r_sclk_q <= sclk;
    end
  end

  // Bit counter and byte-full flag; frozen in IDLE, cleared by start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bitcnt <= 3'd0;
      r_full   <= 1'b0;
    end else if (start) begin
      r_bitcnt <= 3'd0;
      r_full   <= 1'b0;
    end else if (r_state != S_IDLE) begin
      if (w_rise) begin
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) begin
          r_full <= 1'b1;
        end
      end else if (w_byte_done) begin
        r_full <= 1'b0;
      end
    end
  end

  // MSB-first shift register sampling MOSI on each qualified SCLK rise.
  always_ff @(posedge clk) begin
    if (!start && (r_state != S_IDLE) && w_rise) begin
      r_shift <= {r_shift[6:0], sin};
    end
  end

  // State, remaining byte count and captured pin index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_remaining <= 8'd0;
      r_sindex    <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      if (w_sindex_load) begin
        r_sindex <= r_shift;
      end
    end
  end

  // Next state and chip select: scs is ACTIVE-or-entering minus leaving.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_sindex_load   = 1'b0;
    w_scs           = 1'b0;
    if (start) begin
      w_state_nxt = S_GET_INDEX;
    end else begin
      case (r_state)
        S_GET_INDEX: begin
          if (w_byte_done) begin
            w_sindex_load = 1'b1;
            w_state_nxt   = S_GET_COUNT;
          end
        end
        S_GET_COUNT: begin
          if (w_byte_done) begin
            w_remaining_nxt = r_shift;
            if (r_shift != 8'd0) begin
              w_scs       = 1'b1;
              w_state_nxt = S_ACTIVE;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_ACTIVE: begin
          w_scs = 1'b1;
          if (w_byte_done) begin
            w_remaining_nxt = r_remaining - 8'd1;
            if (r_remaining == 8'd1) begin
              w_scs       = 1'b0;
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign scs    = w_scs;
  assign sindex = r_sindex;

endmodule

// File: tb/tb_spi_chip_select_decoder.sv
// Bench for spi_chip_select_decoder: directed frames plus randomized frames,
// checked every cycle against a byte-ordinal model of the frame rules.
module tb_spi_chip_select_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sin = 1'b0;
  logic       sclk = 1'b0;
  logic       scs;
  logic [7:0] sindex;

  spi_chip_select_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sin    (sin),
    .sclk   (sclk),
    .scs    (scs),
    .sindex (sindex)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Driver-owned edge counter, compare-owned transition records.
  int edge_cnt = 0;
  int ntrans = 0;
  int last_rise = -1;
  int last_fall = -1;
  logic scs_seen = 1'b0;

  // Model state: frame progress measured in sampled bits and finished bytes.
  bit         m_prev = 1'b0;
  bit         m_framed = 1'b0;
  int         m_rises = 0;
  int         m_done = 0;
  logic [7:0] m_hold = 8'h00;
  bit         m_bits[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int byteval(input int k);
    int v;
    v = 0;
    for (int i = 0; i < 8; i++) v = (v << 1) | int'(m_bits[8*k+i]);
    return v;
  endfunction

  function automatic logic [7:0] cur_idx();
    if (m_framed && m_done >= 1) return 8'(byteval(0));
    return m_hold;
  endfunction

  // Per-cycle compare against the model, sampled on the falling clk edge.
  always @(negedge clk) begin
    bit         rise_v;
    bit         fall_v;
    int         done_now;
    logic       exp_scs;
    logic [7:0] exp_idx;
    rise_v   = !m_prev && sclk;
    fall_v   = m_prev && !sclk;
    done_now = m_done;
    exp_scs  = 1'b0;
    if (!rst) begin
      exp_idx = 8'h00;
    end else if (start) begin
      exp_idx = cur_idx();
    end else begin
      if (m_framed && fall_v && m_rises >= 8*(m_done+1)) done_now = m_done + 1;
      if (m_framed && done_now >= 2) begin
        if (done_now < 2 + byteval(1)) exp_scs = 1'b1;
      end
      exp_idx = cur_idx();
    end
    check("scs", {31'd0, scs}, {31'd0, exp_scs});
    check("sindex", {24'd0, sindex}, {24'd0, exp_idx});
    if (scs !== scs_seen) begin
      ntrans++;
      if (scs === 1'b1) last_rise = edge_cnt - 1;
      else last_fall = edge_cnt - 1;
      scs_seen = scs;
    end
    if (!rst) begin
      m_framed = 1'b0;
      m_hold   = 8'h00;
      m_rises  = 0;
      m_done   = 0;
      m_bits.delete();
      m_prev   = 1'b0;
    end else if (start) begin
      m_hold   = exp_idx;
      m_framed = 1'b1;
      m_rises  = 0;
      m_done   = 0;
      m_bits.delete();
      m_prev   = sclk;
    end else begin
      if (m_framed && rise_v) begin
        m_bits.push_back(sin);
        m_rises++;
      end
      m_done = done_now;
      m_prev = sclk;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int half);
    for (int i = 7; i >= 0; i--) begin
      sin = b[i];
      repeat (half) tick();
      sclk = 1'b1;
      edge_cnt++;
      repeat (half) tick();
      sclk = 1'b0;
      edge_cnt++;
    end
  endtask

  initial begin
    int base;
    int t0;
    int half;
    int n;
    int sent;
    repeat (3) tick();
    check("reset_scs", {31'd0, scs}, 32'd0);
    check("reset_sindex", {24'd0, sindex}, 32'd0);
    rst = 1'b1;
    tick();

    // Normal frame with traffic before and after.
    base = edge_cnt;
    t0   = ntrans;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 50);
    pulse_start();
    send_byte(8'h43, 50);
    send_byte(8'h02, 50);
    send_byte(8'h43, 50);
    send_byte(8'h43, 50);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 50);
    tick();
    check("normal_ntrans", ntrans - t0, 2);
    check("normal_rise_edge", last_rise - base, 111);
    check("normal_fall_edge", last_fall - base, 143);
    check("normal_sindex", {24'd0, sindex}, 32'h43);

    // Reset in the middle of a frame.
    base = edge_cnt;
    t0   = ntrans;
    pulse_start();
    send_byte(8'h4A, 3);
    pulse_rst();
    check("midrst_sindex", {24'd0, sindex}, 32'd0);
    pulse_start();
    send_byte(8'h43, 3);
    send_byte(8'h02, 3);
    send_byte(8'($urandom), 3);
    send_byte(8'($urandom), 3);
    tick();
    check("midrst_ntrans", ntrans - t0, 2);
    check("midrst_rise_edge", last_rise - base, 47);
    check("midrst_fall_edge", last_fall - base, 79);
    check("midrst_sindex2", {24'd0, sindex}, 32'h43);

    // Zero-length frame.
    t0 = ntrans;
    pulse_start();
    send_byte(8'h10, 2);
    send_byte(8'h00, 2);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 2);
    tick();
    check("zero_ntrans", ntrans - t0, 0);
    check("zero_sindex", {24'd0, sindex}, 32'h10);

    // Restart while active.
    base = edge_cnt;
    t0   = ntrans;
    pulse_start();
    send_byte(8'h05, 2);
    send_byte(8'h03, 2);
    send_byte(8'($urandom), 2);
    pulse_start();
    check("restart_dropped", {31'd0, scs}, 32'd0);
    send_byte(8'h07, 2);
    send_byte(8'h01, 2);
    send_byte(8'($urandom), 2);
    tick();
    check("restart_ntrans", ntrans - t0, 4);
    check("restart_rise_edge", last_rise - base, 79);
    check("restart_fall_edge", last_fall - base, 95);
    check("restart_sindex", {24'd0, sindex}, 32'h07);

    // No start after reset.
    pulse_rst();
    t0 = ntrans;
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1);
    tick();
    check("nostart_ntrans", ntrans - t0, 0);
    check("nostart_sindex", {24'd0, sindex}, 32'd0);

    // Maximum length frame.
    base = edge_cnt;
    t0   = ntrans;
    pulse_start();
    send_byte(8'hFF, 1);
    send_byte(8'hFF, 1);
    for (int i = 0; i < 255; i++) send_byte(8'($urandom), 1);
    send_byte(8'($urandom), 1);
    tick();
    check("max_ntrans", ntrans - t0, 2);
    check("max_rise_edge", last_rise - base, 31);
    check("max_fall_edge", last_fall - base, 31 + 4080);
    check("max_sindex", {24'd0, sindex}, 32'hFF);

    // Randomized frames: truncated, overlong, restarted and reset frames.
    for (int f = 0; f < 30; f++) begin
      half = $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) pulse_rst();
      pulse_start();
      send_byte(8'($urandom), half);
      n = $urandom_range(0, 5);
      send_byte(8'(n), half);
      if ($urandom_range(0, 3) == 0) sent = $urandom_range(0, n);
      else sent = n + $urandom_range(0, 2);
      for (int i = 0; i < sent; i++) send_byte(8'($urandom), half);
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
